// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding and digit constants for the binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [0:0] {
        REPOSO    = 1'b0,
        CONVIERTE = 1'b1
    } estado_t;

    localparam logic [3:0] UMBRAL_BCD = 4'd5;
    localparam logic [3:0] AJUSTE_BCD = 4'd3;
    localparam logic [3:0] DIGITO_MAX = 4'd9;

endpackage

// File: rtl/corrector_digito_bcd.sv
// rtl/corrector_digito_bcd.sv - add-3 correction applied to one BCD digit before each shift
module corrector_digito_bcd
    import bcd_pkg::*;
(
    input  logic [3:0] digito_in,
    output logic [3:0] digito_out
);

    // Largest corrected value is 9+3=12, so four bits never wrap.
    always_comb begin
        digito_out = digito_in;
        if (digito_in >= UMBRAL_BCD) begin
            digito_out = digito_in + AJUSTE_BCD;
        end
    end

endmodule

// File: rtl/binario_a_bcd_serial.sv
// rtl/binario_a_bcd_serial.sv - serial double-dabble converter, one input bit per clock
module binario_a_bcd_serial
    import bcd_pkg::*;
#(
    parameter int N_BITS  = 8,
    parameter int DIGITOS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio,
    input  logic [N_BITS-1:0]    dato_bin,
    output logic                 ocupado,
    output logic                 listo,
    output logic [4*DIGITOS-1:0] bcd,
    output logic                 desborde
);

    localparam int BCD_W = 4 * DIGITOS;
    localparam int CNT_W = $clog2(N_BITS + 1);
    localparam int SH_W  = BCD_W + N_BITS + 1;

    estado_t            estado_q, estado_d;
    logic [N_BITS-1:0]  sreg_bin_q, sreg_bin_d;
    logic [BCD_W-1:0]   sreg_bcd_q, sreg_bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               desborde_q, desborde_d;
    logic               listo_q, listo_d;

    logic [BCD_W-1:0]   bcd_corr;
    logic [SH_W-1:0]    desplazado;
    logic               bit_out;
    logic [BCD_W-1:0]   bcd_sig;
    logic [N_BITS-1:0]  bin_sig;
    logic               ultimo;

    for (genvar g = 0; g < DIGITOS; g++) begin : g_corr
        corrector_digito_bcd u_corr (
            .digito_in  (sreg_bcd_q[4*g +: 4]),
            .digito_out (bcd_corr[4*g +: 4])
        );
    end

    // The bit leaving the top digit is what the result could not hold.
    assign desplazado = {bcd_corr, sreg_bin_q, 1'b0};
    assign bit_out    = desplazado[SH_W-1];
    assign bcd_sig    = desplazado[SH_W-2 -: BCD_W];
    assign bin_sig    = desplazado[N_BITS-1:0];
    assign ultimo     = (cnt_q == CNT_W'(N_BITS - 1));

    always_comb begin
        estado_d   = estado_q;
        sreg_bin_d = sreg_bin_q;
        sreg_bcd_d = sreg_bcd_q;
        cnt_d      = cnt_q;
        ovf_acc_d  = ovf_acc_q;
        bcd_d      = bcd_q;
        desborde_d = desborde_q;
        listo_d    = 1'b0;
        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    sreg_bin_d = dato_bin;
                    sreg_bcd_d = '0;
                    ovf_acc_d  = 1'b0;
                    cnt_d      = '0;
                    estado_d   = CONVIERTE;
                end
            end
            CONVIERTE: begin
                sreg_bin_d = bin_sig;
                sreg_bcd_d = bcd_sig;
                ovf_acc_d  = ovf_acc_q | bit_out;
                cnt_d      = cnt_q + CNT_W'(1);
                if (ultimo) begin
                    bcd_d      = bcd_sig;
                    desborde_d = ovf_acc_q | bit_out;
                    listo_d    = 1'b1;
                    estado_d   = REPOSO;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= REPOSO;
            sreg_bin_q <= '0;
            sreg_bcd_q <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            bcd_q      <= '0;
            desborde_q <= 1'b0;
            listo_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            sreg_bin_q <= sreg_bin_d;
            sreg_bcd_q <= sreg_bcd_d;
            cnt_q      <= cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            bcd_q      <= bcd_d;
            desborde_q <= desborde_d;
            listo_q    <= listo_d;
        end
    end

    assign ocupado  = (estado_q == CONVIERTE);
    assign listo    = listo_q;
    assign bcd      = bcd_q;
    assign desborde = desborde_q;

endmodule
